slice_cfg_loader: RTL and testbench

Configuration sequencer for one fractured-carry logic slice.
- Accepts a word-serial configuration stream over a valid/ready handshake.
- Assembles the full slice configuration: every LUT's fracturable config, the carry-chain enable, and the inter-LUT mux select.
- Issues a single-cycle `cen` commit pulse so the slice latches the new image atomically.
- Sits between the fabric configuration bus and the slice's config ports; the slice's `cclk` is driven from this block's `clk` at top level.

---
 rtl/slice_cfg_pkg.sv | 43 ++++
 rtl/slice_cfg_loader_deserializer.sv | 65 ++++++
 rtl/slice_cfg_loader.sv | 142 ++++++++++++++
 tb/tb_slice_cfg_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_cfg_pkg.sv
// rtl/slice_cfg_pkg.sv - shared types, sizing functions and field offsets for the slice config loader
package slice_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    function automatic int cfg_size(input int base);
        return (2 ** base) + 1;
    endfunction

    function automatic int total_bits(input int base, input int luts);
        return luts * 2 * cfg_size(base) + 1 + $clog2(luts);
    endfunction

    function automatic int num_words(input int base, input int luts, input int word_w);
        return (total_bits(base, luts) + word_w - 1) / word_w;
    endfunction

    function automatic int lut_offset(input int base, input int idx);
        return idx * 2 * cfg_size(base);
    endfunction

    function automatic int use_cc_offset(input int base, input int luts);
        return luts * 2 * cfg_size(base);
    endfunction

    // Mux select sits directly above the carry-chain enable, at the top of the image.
    function automatic int mux_offset(input int base, input int luts);
        return use_cc_offset(base, luts) + 1;
    endfunction

    localparam int DEF_S_XX_BASE     = 4;
    localparam int DEF_NUM_LUTS      = 4;
    localparam int DEF_WORD_W        = 8;
    localparam int DEF_CFG_SIZE      = cfg_size(DEF_S_XX_BASE);
    localparam int DEF_LUT_OFFSET_1  = lut_offset(DEF_S_XX_BASE, 1);
    localparam int DEF_USE_CC_OFFSET = use_cc_offset(DEF_S_XX_BASE, DEF_NUM_LUTS);
    localparam int DEF_MUX_OFFSET    = mux_offset(DEF_S_XX_BASE, DEF_NUM_LUTS);

endpackage

// File: rtl/slice_cfg_loader_deserializer.sv
// rtl/slice_cfg_loader_deserializer.sv - word counter, indexed image write and running XOR
module cfg_word_deserializer
    import slice_cfg_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int TOTAL_BITS = 139,
    parameter int NUM_WORDS  = 18,
    parameter int NUM_XFER   = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  capture,
    input  logic [WORD_W-1:0]     data,
    output logic                  last_word,
    output logic [WORD_W-1:0]     xor_acc,
    output logic [TOTAL_BITS-1:0] image
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int PAD_W = NUM_WORDS * WORD_W;

    logic [CNT_W-1:0] count;
    logic [PAD_W-1:0] words_q;

    assign last_word = (count == CNT_W'(NUM_XFER - 1));

    // The counter parks on the final index so it cannot wrap before the next clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            xor_acc <= '0;
        end else if (clear) begin
            count   <= '0;
            xor_acc <= '0;
        end else if (capture) begin
            xor_acc <= xor_acc ^ data;
            if (!last_word) begin
                count <= count + 1'b1;
            end
        end
    end

    // A checksum word lands on index NUM_WORDS and therefore never touches the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else if (capture) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (count == CNT_W'(w)) begin
                    words_q[w*WORD_W +: WORD_W] <= data;
                end
            end
        end
    end

    assign image = words_q[TOTAL_BITS-1:0];

    generate
        if (PAD_W > TOTAL_BITS) begin : g_pad
            wire unused_pad = ^words_q[PAD_W-1:TOTAL_BITS];
        end
    endgenerate

endmodule

// File: rtl/slice_cfg_loader.sv
// rtl/slice_cfg_loader.sv - slice configuration sequencer; optional checksum word via SLICE_CFG_PARITY_EN
module slice_cfg_loader
    import slice_cfg_pkg::*;
#(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4,
    parameter int WORD_W    = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [WORD_W-1:0]                             cfg_data,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    output logic [NUM_LUTS-1:0][2*cfg_size(S_XX_BASE)-1:0] luts_config_out,
    output logic                                          config_use_cc,
    output logic [$clog2(NUM_LUTS)-1:0]                   inter_lut_mux_config,
    output logic                                          cen,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err
);

    localparam int CFG_SIZE   = cfg_size(S_XX_BASE);
    localparam int LUT_W      = 2 * CFG_SIZE;
    localparam int MUX_LVLS   = $clog2(NUM_LUTS);
    localparam int TOTAL_BITS = total_bits(S_XX_BASE, NUM_LUTS);
    localparam int NUM_WORDS  = num_words(S_XX_BASE, NUM_LUTS, WORD_W);
    localparam int USE_CC_OFF = use_cc_offset(S_XX_BASE, NUM_LUTS);
    localparam int MUX_OFF    = mux_offset(S_XX_BASE, NUM_LUTS);
`ifdef SLICE_CFG_PARITY_EN
    localparam int NUM_XFER   = NUM_WORDS + 1;
`else
    localparam int NUM_XFER   = NUM_WORDS;
`endif

    cfg_state_t              state_q;
    cfg_state_t              state_d;
    logic                    capture;
    logic                    clear;
    logic                    fail;
    logic                    sum_ok;
    logic                    last_word;
    logic [WORD_W-1:0]       xor_acc;
    logic [TOTAL_BITS-1:0]   image;
    logic                    done_q;

    cfg_word_deserializer #(
        .WORD_W     (WORD_W),
        .TOTAL_BITS (TOTAL_BITS),
        .NUM_WORDS  (NUM_WORDS),
        .NUM_XFER   (NUM_XFER)
    ) u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .capture   (capture),
        .data      (cfg_data),
        .last_word (last_word),
        .xor_acc   (xor_acc),
        .image     (image)
    );

`ifdef SLICE_CFG_PARITY_EN
    // At the checksum word the accumulator holds the XOR of all data words only.
    assign sum_ok = (cfg_data == xor_acc);

    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clear) begin
            err_q <= 1'b0;
        end else if (fail) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign sum_ok = 1'b1;
    assign err    = 1'b0;
    wire unused_chk = ^{xor_acc, fail};
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        clear   = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cfg_valid) begin
                    capture = 1'b1;
                    if (last_word) begin
                        if (sum_ok) begin
                            state_d = COMMIT;
                        end else begin
                            state_d = IDLE;
                            fail    = 1'b1;
                        end
                    end
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == COMMIT);
        end
    end

    assign cfg_ready = (state_q == LOAD);
    assign cen       = (state_q == COMMIT);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    generate
        for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
            assign luts_config_out[i] = image[i*LUT_W +: LUT_W];
        end
    endgenerate

    assign config_use_cc        = image[USE_CC_OFF];
    assign inter_lut_mux_config = image[MUX_OFF +: MUX_LVLS];

endmodule

// File: tb/tb_slice_cfg_loader.sv
// tb/tb_slice_cfg_loader.sv - scoreboard bench for slice_cfg_loader at default parameters
module tb_slice_cfg_loader;

    localparam int NW = 18;
`ifdef SLICE_CFG_PARITY_EN
    localparam int NX = NW + 1;
`else
    localparam int NX = NW;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [7:0]        cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0][33:0]  luts_config_out;
    logic              config_use_cc;
    logic [1:0]        inter_lut_mux_config;
    logic              cen;
    logic              busy;
    logic              done;
    logic              err;

    slice_cfg_loader dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .cfg_data             (cfg_data),
        .cfg_valid            (cfg_valid),
        .cfg_ready            (cfg_ready),
        .luts_config_out      (luts_config_out),
        .config_use_cc        (config_use_cc),
        .inter_lut_mux_config (inter_lut_mux_config),
        .cen                  (cen),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;
    int cen_count = 0, done_count = 0, hs_count = 0;
    int cen_cyc = 0, done_cyc = 0, accept_cyc = 0, start_cyc = 0;
    int c0, d0, h0;
    logic [7:0]   wbuf [0:18];
    logic [143:0] model_flat;
    logic [138:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_image(input string tag, input logic [138:0] img);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_lut%0d", tag, i), luts_config_out[i], img[i*34 +: 34]);
        end
        check({tag, "_use_cc"}, config_use_cc, img[136]);
        check({tag, "_mux"}, inter_lut_mux_config, img[138:137]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cen) begin
                cen_count++;
                cen_cyc = cyc;
                if (exp_q.size() == 0) check("cen_unexpected", 1, 0);
                else check_image("commit", exp_q.pop_front());
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (cfg_valid && cfg_ready && !abort) hs_count++;
        end
    end

    task automatic fill_words(input int mode);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < NW; k++) begin
            wbuf[k] = (mode == 0) ? 8'(k + 1) : 8'($urandom_range(0, 255));
            x = x ^ wbuf[k];
        end
        wbuf[NW] = x;
    endtask

    task automatic do_start(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic send_words(input int first, input int n, input logic stall);
        int bound;
        for (int k = first; k < first + n; k++) begin
            if (stall) begin
                cfg_valid = 1'b0;
                @(posedge clk); #1;
            end
            cfg_valid = 1'b1;
            cfg_data  = wbuf[k];
            bound = 0;
            while (!cfg_ready && bound < 20) begin
                @(posedge clk); #1;
                bound++;
            end
            if (!cfg_ready) check("ready_timeout", 0, 1);
            @(posedge clk); #1;
            accept_cyc = cyc - 1;
            if (k < NW) model_flat[k*8 +: 8] = wbuf[k];
        end
        cfg_valid = 1'b0;
    endtask

    task automatic mark();
        c0 = cen_count;
        d0 = done_count;
        h0 = hs_count;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        model_flat = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_ready", cfg_ready, 0);
        check("rst_cen", cen, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check_image("rst", '0);

        // Valid words without start are never accepted.
        rst_n = 1'b1;
        cfg_valid = 1'b1; cfg_data = 8'hA5;
        repeat (5) @(posedge clk); #1;
        check("idle_ready", cfg_ready, 0);
        check("idle_busy", busy, 0);
        cfg_valid = 1'b0;
        check("idle_cen_count", cen_count, 0);
        check_image("idle", '0);

        // Back-to-back load of 0x01..0x12.
        fill_words(0); mark();
        do_start(1'b0);
        send_words(0, NX, 1'b0);
        exp_q.push_back(model_flat[138:0]);
        repeat (3) @(posedge clk); #1;
        check("b2b_cen_cycle", cen_cyc - start_cyc, NX + 1);
        check("b2b_done_cycle", done_cyc - start_cyc, NX + 2);
        check("b2b_cen_pulses", cen_count - c0, 1);
        check("b2b_done_pulses", done_count - d0, 1);
        check("b2b_captures", hs_count - h0, NX);
        check("b2b_lut0_lit", luts_config_out[0], 34'h1_0403_0201);
        check("b2b_use_cc_lit", config_use_cc, 1'b0);
        check("b2b_mux_lit", inter_lut_mux_config, 2'b01);

        // Stalled stream, plus a start pulse while busy that must be ignored.
        mark();
        do_start(1'b0);
        send_words(0, 5, 1'b1);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        send_words(5, NX - 5, 1'b1);
        exp_q.push_back(model_flat[138:0]);
        repeat (3) @(posedge clk); #1;
        check("stall_cen_after_last", cen_cyc - accept_cyc, 1);
        check("stall_cen_pulses", cen_count - c0, 1);
        check("stall_done_pulses", done_count - d0, 1);
        check("stall_captures", hs_count - h0, NX);

        // Abort after 7 words; the word presented with abort is dropped.
        fill_words(1); mark();
        do_start(1'b0);
        send_words(0, 7, 1'b0);
        abort = 1'b1; cfg_valid = 1'b1; cfg_data = ~wbuf[7];
        @(posedge clk); #1;
        abort = 1'b0; cfg_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", cfg_ready, 0);
        repeat (25) @(posedge clk); #1;
        check("abort_cen_pulses", cen_count - c0, 0);
        check("abort_done_pulses", done_count - d0, 0);
        check_image("abort_partial", model_flat[138:0]);
        fill_words(2); mark();
        do_start(1'b0);
        send_words(0, NX, 1'b0);
        exp_q.push_back(model_flat[138:0]);
        repeat (3) @(posedge clk); #1;
        check("reload_cen_pulses", cen_count - c0, 1);

        // Asynchronous reset during word 10, then a clean load.
        fill_words(3);
        do_start(1'b0);
        send_words(0, 10, 1'b0);
        cfg_valid = 1'b1; cfg_data = wbuf[10];
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_cen", cen, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", cfg_ready, 0);
        check("rstmid_done", done, 0);
        check_image("rstmid", '0);
        model_flat = '0;
        @(posedge clk); #1;
        rst_n = 1'b1; cfg_valid = 1'b0;
        mark();
        do_start(1'b1);
        check("start_beats_abort", busy, 1);
        send_words(0, NX, 1'b0);
        exp_q.push_back(model_flat[138:0]);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("commit_abort_cen", cen_count - c0, 1);
        check("commit_abort_done", done_count - d0, 1);

`ifdef SLICE_CFG_PARITY_EN
        fill_words(4); mark();
        do_start(1'b0);
        send_words(0, NX, 1'b0);
        exp_q.push_back(model_flat[138:0]);
        repeat (3) @(posedge clk); #1;
        check("par_ok_cen", cen_count - c0, 1);
        check("par_ok_err", err, 0);

        fill_words(5); mark();
        wbuf[NW] = wbuf[NW] ^ 8'h01;
        do_start(1'b0);
        send_words(0, NX, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("par_bad_cen", cen_count - c0, 0);
        check("par_bad_done", done_count - d0, 0);
        check("par_bad_busy", busy, 0);
        check("par_bad_err", err, 1);
        repeat (10) @(posedge clk); #1;
        check("par_err_sticky", err, 1);
        mark();
        do_start(1'b0);
        check("par_err_cleared", err, 0);
        wbuf[NW] = wbuf[NW] ^ 8'h01;
        send_words(0, NX, 1'b0);
        exp_q.push_back(model_flat[138:0]);
        repeat (3) @(posedge clk); #1;
        check("par_retry_cen", cen_count - c0, 1);
`else
        check("err_tied", err, 0);
`endif

        repeat (3) @(posedge clk); #1;
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
